// File: rtl/dma_copy_engine.sv
// ============================================================================
// Module      : dma_copy_engine
// Description : Word-granular memory-to-memory copy engine programmed through
//               CPU DMA-store writes. Moves LEN words from SRC to DST over a
//               single-outstanding req/ack master port, stalls the CPU while
//               busy and pulses done on completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_copy_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // CPU DMA-store side (write-only register port)
  input  logic              valid_cpu2dma_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_dma2cpu_o,
  output logic              busy_o,
  output logic              done_o,
  // Memory master side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [LEN_W-1:0]  remain;

  logic              wr_accept;
  logic [ADDR_W-1:0] wdata_aligned;
  logic [ADDR_W-1:0] next_src;
  logic [ADDR_W-1:0] next_dst;
  logic              unused_addr_bits;

  assign wr_accept        = valid_cpu2dma_i & ready_dma2cpu_o;
  assign wdata_aligned    = ADDR_W'(wdata_i) & ALIGN_MASK;
  assign next_src         = cur_src + WORD_BYTES;
  assign next_dst         = cur_dst + WORD_BYTES;
  // Only addr_i[3:2] selects a register; the rest is intentionally ignored.
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:4], addr_i[1:0]};

  // Copy FSM: config registers, copy pointers and all outputs are registered
  // here. mem_wdata_o doubles as the read-data buffer between RD and WR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      src_reg         <= '0;
      dst_reg         <= '0;
      len_reg         <= '0;
      cur_src         <= '0;
      cur_dst         <= '0;
      remain          <= '0;
      ready_dma2cpu_o <= 1'b1;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      mem_req_o       <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_accept) begin
            case (addr_i[3:2])
              2'd0: src_reg <= wdata_aligned;
              2'd1: dst_reg <= wdata_aligned;
              2'd2: len_reg <= wdata_i[LEN_W-1:0];
              default: begin
                if (wdata_i[0]) begin
                  ready_dma2cpu_o <= 1'b0;
                  busy_o          <= 1'b1;
                  if (len_reg != '0) begin
                    // Snapshot config so the copy never disturbs SRC/DST/LEN.
                    state      <= RD;
                    cur_src    <= src_reg;
                    cur_dst    <= dst_reg;
                    remain     <= len_reg;
                    mem_req_o  <= 1'b1;
                    mem_we_o   <= 1'b0;
                    mem_addr_o <= src_reg;
                  end else begin
                    state  <= DONE;
                    done_o <= 1'b1;
                  end
                end
              end
            endcase
          end
        end

        RD: begin
          if (mem_ack_i) begin
            state       <= WR;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= cur_dst;
            mem_wdata_o <= mem_rdata_i;
          end
        end

        WR: begin
          if (mem_ack_i) begin
            cur_src  <= next_src;
            cur_dst  <= next_dst;
            remain   <= remain - LEN_ONE;
            mem_we_o <= 1'b0;
            if (remain == LEN_ONE) begin
              state      <= DONE;
              mem_req_o  <= 1'b0;
              mem_addr_o <= '0;
              done_o     <= 1'b1;
            end else begin
              state      <= RD;
              mem_addr_o <= next_src;
            end
          end
        end

        default: begin
          state           <= IDLE;
          done_o          <= 1'b0;
          busy_o          <= 1'b0;
          ready_dma2cpu_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
// ============================================================================
// Module      : tb_dma_copy_engine
// Description : Self-checking bench for dma_copy_engine with a req/ack memory
//               responder (random wait states) and a word-list copy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, busy, done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  dma_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_cpu2dma_i(valid), .addr_i(addr), .wdata_i(wdata),
    .ready_dma2cpu_o(ready), .busy_o(busy), .done_o(done),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [logic [31:0]];
  xact_t       log_q[$];
  int          max_delay = 0;
  // Programmed-register model
  logic [31:0] m_src = '0, m_dst = '0;
  logic [15:0] m_len = '0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0F0F);
  endfunction

  // Memory responder: random wait states, logs every acknowledged transfer,
  // and checks that the request is held stable while waiting.
  logic        in_req = 1'b0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  int          wcnt, dly;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_n || !mem_req) begin
      in_req = 1'b0;
    end else begin
      if (!in_req) begin
        in_req  = 1'b1;
        h_we    = mem_we;
        h_addr  = mem_addr;
        h_wdata = mem_wdata;
        wcnt    = 0;
        dly     = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
      end else begin
        check("req_stable", {mem_we, mem_addr, mem_wdata}, {h_we, h_addr, h_wdata});
      end
      if (wcnt >= dly) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem_rd(mem_addr);
        log_q.push_back('{we: mem_we, addr: mem_addr, data: mem_we ? mem_wdata : mem_rdata});
        in_req = 1'b0;
      end else begin
        wcnt++;
      end
    end
  end

  // One accepted CPU register write; random don't-care address bits.
  task automatic cpu_write(input logic [1:0] idx, input logic [31:0] d);
    int n = 0;
    logic [31:0] r;
    @(negedge clk);
    r = $urandom();
    valid = 1'b1;
    addr  = {r[31:4], idx, r[1:0]};
    wdata = d;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("cpu_write_accept", ready, 1'b1);
    @(posedge clk);
    #1 valid = 1'b0;
    case (idx)
      2'd0: m_src = d & 32'hFFFF_FFFC;
      2'd1: m_dst = d & 32'hFFFF_FFFC;
      2'd2: m_len = d[15:0];
      default: ;
    endcase
  endtask

  // Issue START and check done timing, pulse count and the bus transfer list
  // against the word-by-word copy the model predicts.
  task automatic run_start(input int exp_done);
    xact_t exp_q[$];
    int first = -1, pulses = 0;
    logic [31:0] a, v;
    for (int i = 0; i < int'(m_len); i++) begin
      a = m_src + 32'(4 * i);
      v = mem_rd(a);
      exp_q.push_back('{we: 1'b0, addr: a, data: v});
      exp_q.push_back('{we: 1'b1, addr: m_dst + 32'(4 * i), data: v});
    end
    log_q.delete();
    cpu_write(2'd3, 32'h1);
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      if (m_len == 0 && k <= 2) check("zero_len_busy", busy, (k == 1));
      if (done) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (first >= 0 && k > first) break;
    end
    check("done_seen", (first >= 0), 1'b1);
    if (exp_done >= 0) check("done_latency", first, exp_done);
    check("done_pulses", pulses, 1);
    check("xfer_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check("xfer", log_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic [31:0] saved [8];

    // Reset state
    #12;
    check("rst_outputs", {ready, busy, done, mem_req, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // Configuration only: no bus activity, outputs idle
    log_q.delete();
    cpu_write(2'd0, 32'h1000);
    cpu_write(2'd1, 32'h2003);
    cpu_write(2'd2, 32'h3);
    @(negedge clk);
    check("cfg_idle_outputs", {ready, busy, done, mem_req, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    check("cfg_no_bus", log_q.size(), 0);

    // Zero-wait copy of three words; DST lands word-aligned at 0x2000
    mem[32'h1000] = 32'hAAAA_0001;
    mem[32'h1004] = 32'hBBBB_0002;
    mem[32'h1008] = 32'hCCCC_0003;
    run_start(7);
    check("dst_aligned_w0", mem_rd(32'h2000), 32'hAAAA_0001);
    check("dst_aligned_w2", mem_rd(32'h2008), 32'hCCCC_0003);

    // Wait-state memory, random regions, LEN=8
    max_delay = 5;
    cpu_write(2'd0, 32'h4000 + ($urandom_range(63, 0) << 2));
    cpu_write(2'd1, 32'h8000 + ($urandom_range(63, 0) << 2));
    cpu_write(2'd2, 32'd8);
    for (int i = 0; i < 8; i++) begin
      saved[i] = $urandom();
      mem[m_src + 32'(4 * i)] = saved[i];
    end
    run_start(-1);
    for (int i = 0; i < 8; i++) check("ws_dst_data", mem_rd(m_dst + 32'(4 * i)), saved[i]);
    max_delay = 0;

    // Stall: LEN write during a LEN=4 copy is held until the cycle after done
    cpu_write(2'd2, 32'd4);
    cpu_write(2'd3, 32'h1);
    first = -1;
    @(negedge clk);
    valid = 1'b1;
    addr  = 32'h0000_0008;
    wdata = 32'd5;
    for (int k = 1; k <= 100; k++) begin
      if (done && first < 0) first = k;
      if (first >= 0 && k == first + 1) begin
        check("stall_ready_after_done", ready, 1'b1);
        break;
      end
      check("stall_ready_low", ready, 1'b0);
      @(negedge clk);
    end
    check("stall_done_latency", first, 9);
    @(posedge clk);
    #1 valid = 1'b0;
    m_len = 16'd5;
    run_start(11);

    // START with LEN=0: done next cycle, no bus traffic
    cpu_write(2'd2, 32'h0);
    run_start(1);

    // Address wrap at the top of memory
    cpu_write(2'd0, 32'hFFFF_FFFC);
    cpu_write(2'd1, 32'h3000);
    cpu_write(2'd2, 32'd2);
    run_start(5);
    if (log_q.size() > 2) check("wrap_rd2_addr", log_q[2].addr, 32'h0);
    else                  check("wrap_rd2_present", log_q.size(), 3);

    // Abort in WR by asynchronous reset
    cpu_write(2'd0, 32'h1000);
    cpu_write(2'd1, 32'h5000);
    cpu_write(2'd2, 32'd4);
    cpu_write(2'd3, 32'h1);
    for (int k = 0; k < 20 && !mem_we; k++) @(negedge clk);
    check("abort_reached_wr", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {ready, busy, done, mem_req, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", {done, mem_req}, 2'b00);
    end
    #1 rst_n = 1'b1;
    m_src = '0;
    m_dst = '0;
    m_len = '0;
    // LEN cleared: START finishes immediately with no traffic
    run_start(1);
    // SRC/DST cleared: one word copied from 0 to 0
    cpu_write(2'd2, 32'd1);
    run_start(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-granular memory-to-memory copy engine at the DMA end of the CPU's DMA-store path. The CPU programs it with DMA-store instructions, asserted as `valid_cpu2dma_i` with the ALU result as register address and rs2 as data. Once started, the engine copies LEN 32-bit words from SRC to DST over a single-outstanding req/ack memory master port. It stalls the CPU while a copy is in progress and pulses `done_o` at completion.

## Interface
- `ADDR_W`, 32: address width of the CPU and memory sides.
- `DATA_W`, 32: data width; one word is moved per read/write pair.
- `LEN_W`, 16: width of the LEN register (word count).

Ports:
- `clk_i` in 1: single clock; all state changes on its rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `valid_cpu2dma_i` in 1: CPU DMA-store request this cycle.
- `addr_i` in ADDR_W: register address; only bits [3:2] are decoded.
- `wdata_i` in DATA_W: register write data.
- `ready_dma2cpu_o` out 1: write accepted this cycle. When low, the CPU holds the request.
- `busy_o` out 1: a copy is in progress.
- `done_o` out 1: one-cycle completion pulse.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = write, 0 = read.
- `mem_addr_o` out ADDR_W: word-aligned memory address.
- `mem_wdata_o` out DATA_W: write data.
- `mem_ack_i` in 1: one-cycle acknowledge of the current request.
- `mem_rdata_i` in DATA_W: read data, valid in the ack cycle of a read.

## Operation
- Register map, selected by `addr_i[3:2]`:
  - 0 SRC: bits [1:0] are forced to 0 on write.
  - 1 DST: bits [1:0] are forced to 0 on write.
  - 2 LEN: `wdata_i[LEN_W-1:0]`.
  - 3 CTRL: bit0 = START. Writing 0 has no effect.
- There is no readback; the interface is write-only.
- A write is accepted when `valid_cpu2dma_i & ready_dma2cpu_o`. `ready_dma2cpu_o` = (state == IDLE), so writes are accepted only in IDLE.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - An accepted CTRL write with START=1 and LEN≠0 loads `cur_src`=SRC, `cur_dst`=DST, `remain`=LEN, then goes to RD.
  - An accepted CTRL write with START=1 and LEN=0 goes to DONE with no bus traffic.
- START uses SRC/DST/LEN as stored before that edge. Config written in earlier cycles is used; a CTRL write cannot change them.
- RD: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=`cur_src`. On `mem_ack_i`, latch `mem_rdata_i` into `buf` and go to WR.
- WR: `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`=`cur_dst`, `mem_wdata_o`=`buf`. On `mem_ack_i`:
  - `cur_src`+=4, `cur_dst`+=4, `remain`-=1.
  - If the old `remain`==1, go to DONE; else go to RD.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `busy_o`=1 in RD, WR and DONE.
- Address increments wrap modulo 2^ADDR_W; there is no fault on wrap.
- SRC/DST/LEN registers are not modified by a copy. Re-issuing START repeats the same copy.
- Overlapping regions are copied in ascending address order; no overlap protection.
- `mem_ack_i` while `mem_req_o`=0 is ignored.

## Timing
- Reset values (asynchronous, immediate on `rst_ni`=0):
  - SRC, DST, LEN, `cur_*`, `remain`, `buf` = 0; state = IDLE.
  - `ready_dma2cpu_o`=1; `busy_o`=0; `done_o`=0.
  - `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- Reset mid-copy aborts immediately: `mem_req_o` drops in the same cycle, with no `done_o` pulse.
- All outputs are registered or decoded from state/registers only. There is no combinational path from `mem_ack_i` or `valid_cpu2dma_i` to any output.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held stable from request until the ack cycle inclusive.
- An ack may arrive in the first request cycle. In that case the next request (or DONE) begins the following cycle.
- START accepted at edge N:
  - RD is active in cycle N+1.
  - With zero-wait acks, each word takes 2 cycles.
  - `done_o` is high in the cycle after the final write ack.
  - Total latency = 2·LEN + 1 cycles from START to the `done_o` cycle.
- LEN=0: `done_o` is high in cycle N+1, and `busy_o` is high that cycle only.
- CPU writes arriving while busy see `ready_dma2cpu_o`=0 until the cycle after DONE (IDLE), and are accepted then.

## Test plan
- Reset and config: program SRC=0x1000, DST=0x2003, LEN=3 via three accepted writes.
  - No bus activity occurs.
  - All outputs stay at reset values.
  - Internally DST = 0x2000.
- Copy with zero-wait acks: START with LEN=3, memory[0x1000..0x1008]=A,B,C.
  - Bus sequence is R 0x1000, W 0x2000=A, R 0x1004, W 0x2004=B, R 0x1008, W 0x2008=C.
  - `done_o` appears at cycle 7 after START.
- Wait-state memory: random 0–5 cycle ack delay, LEN=8.
  - Request signals are stable until ack.
  - Destination matches source.
  - Exactly one `done_o` pulse.
- Stall and zero length:
  - A CPU write to LEN during a copy is held with `ready_dma2cpu_o`=0 and accepted the cycle after DONE.
  - START with LEN=0 gives `done_o` at N+1 with no `mem_req_o`.
- Wrap and abort:
  - SRC=0xFFFFFFFC, LEN=2: second read is to 0x00000000.
  - Asserting `rst_ni`=0 during WR drops `mem_req_o` immediately, with no `done_o` pulse, and all registers read as 0 after release.
